// File: rtl/eco32_core_wbu_pkg.sv
// rtl/eco32_core_wbu_pkg.sv - shared write-back unit types and field widths
//
// Purpose: FSM state encodings, half-enable bit indices and entry field widths
//          common to the write-back FIFO stage and the register-file writer.
// Ports:   none (package)
package eco32_core_wbu_pkg;

  localparam int ADDR_W = 5;
  localparam int ENA_W  = 2;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 1;
  localparam int HALF_W = DATA_W / 2;

  // Half-enable bit indices: [0] covers bits 15:0, [1] covers bits 31:16.
  localparam int HALF_LO = 0;
  localparam int HALF_HI = 1;

  typedef enum logic {
    ST_A = 1'b0,
    ST_B = 1'b1
  } state_t;

  // One register-file write: half enables, data and tag.
  typedef struct packed {
    logic [ENA_W-1:0]  ena;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } wr_t;

endpackage

// File: rtl/eco32_core_wbu_rfw_if.sv
// rtl/eco32_core_wbu_rfw_if.sv - FIFO entry, rf write port and scoreboard release bundle
//
// Purpose: groups the write-back FIFO entry handshake, the register-file write
//          port and the scoreboard release into one interface.
// Ports:   slave  - the rf writer: takes i_* entry fields, drives i_ack, rf_*, sb_*
//          master - the FIFO/environment side: the reverse directions
interface eco32_core_wbu_rfw_if;
  import eco32_core_wbu_pkg::*;

  logic              i_stb;
  logic              i_clr;
  logic [ADDR_W-1:0] i_addr;
  logic [ENA_W-1:0]  i_a_ena;
  logic [DATA_W-1:0] i_a_data;
  logic [TAG_W-1:0]  i_a_tag;
  logic [ENA_W-1:0]  i_b_ena;
  logic              i_b_mode;
  logic [DATA_W-1:0] i_b_data;
  logic [TAG_W-1:0]  i_b_tag;
  logic              i_ack;

  logic              rf_stb;
  logic [ADDR_W-1:0] rf_addr;
  logic [ENA_W-1:0]  rf_ena;
  logic [DATA_W-1:0] rf_data;
  logic [TAG_W-1:0]  rf_tag;

  logic              sb_clr;
  logic [ADDR_W-1:0] sb_addr;

  modport slave (
    input  i_stb, i_clr, i_addr, i_a_ena, i_a_data, i_a_tag,
           i_b_ena, i_b_mode, i_b_data, i_b_tag,
    output i_ack, rf_stb, rf_addr, rf_ena, rf_data, rf_tag, sb_clr, sb_addr
  );

  modport master (
    output i_stb, i_clr, i_addr, i_a_ena, i_a_data, i_a_tag,
           i_b_ena, i_b_mode, i_b_data, i_b_tag,
    input  i_ack, rf_stb, rf_addr, rf_ena, rf_data, rf_tag, sb_clr, sb_addr
  );

endinterface

// File: rtl/eco32_core_wbu_merge.sv
// rtl/eco32_core_wbu_merge.sv - combinational A/B half merge into W0/W1 writes
//
// Purpose: b_mode=0 folds B into the primary write half by half (B wins where
//          enabled); b_mode=1 keeps A as W0 and sends B out as W1 (pair reg).
// Ports:   a_ena/a_data/a_tag  A result fields
//          b_ena/b_data/b_tag  B result fields, b_mode selects merge or pair
//          w0                  primary write to the entry address
//          w1                  secondary write to address^1 (ena=0 if unused)
module eco32_core_wbu_merge
  import eco32_core_wbu_pkg::*;
(
  input  logic [ENA_W-1:0]  a_ena,
  input  logic [DATA_W-1:0] a_data,
  input  logic [TAG_W-1:0]  a_tag,
  input  logic [ENA_W-1:0]  b_ena,
  input  logic              b_mode,
  input  logic [DATA_W-1:0] b_data,
  input  logic [TAG_W-1:0]  b_tag,
  output wr_t               w0,
  output wr_t               w1
);

  always_comb begin
    w0 = '0;
    w1 = '0;
    if (b_mode) begin
      w0.ena  = a_ena;
      w0.data = a_data;
      w0.tag  = a_tag;
      w1.ena  = b_ena;
      w1.data = b_data;
      w1.tag  = b_tag;
    end else begin
      w0.ena = a_ena | b_ena;
      w0.data[HALF_LO*HALF_W +: HALF_W] = b_ena[HALF_LO] ? b_data[HALF_LO*HALF_W +: HALF_W]
                                                          : a_data[HALF_LO*HALF_W +: HALF_W];
      w0.data[HALF_HI*HALF_W +: HALF_W] = b_ena[HALF_HI] ? b_data[HALF_HI*HALF_W +: HALF_W]
                                                          : a_data[HALF_HI*HALF_W +: HALF_W];
      // Any B contribution makes B the owner of the tag.
      w0.tag = (b_ena != '0) ? b_tag : a_tag;
    end
  end

endmodule

// File: rtl/eco32_core_wbu_rfw.sv
// rtl/eco32_core_wbu_rfw.sv - register-file writer at the write-back FIFO output
//
// Purpose: pops one FIFO entry per handshake and drives the single rf write
//          port, splitting pair writes over two cycles (ST_A then ST_B), and
//          issues the scoreboard release with the entry's last write.
// Ports:   clk      clock
//          rst      asynchronous active-low reset
//          x_stall  freeze: no pop, no rf write, FSM and captured data hold
//          bus      slave side of eco32_core_wbu_rfw_if (entry in, rf/sb out)
module eco32_core_wbu_rfw
  import eco32_core_wbu_pkg::*;
#(
  parameter bit R0_PROTECT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_stall,
  eco32_core_wbu_rfw_if.slave   bus
);

  state_t            state, state_nxt;
  wr_t               w0, w1;
  wr_t               cap_w1;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_clr;

  logic              active;
  logic              pair;
  logic              ack;
  logic              go_b;
  logic              issue;
  logic [ADDR_W-1:0] iss_addr;
  wr_t               iss_w;
  logic              iss_clr;
  logic [ADDR_W-1:0] iss_clr_addr;
  logic              rf_wr;

  eco32_core_wbu_merge u_merge (
    .a_ena  (bus.i_a_ena),
    .a_data (bus.i_a_data),
    .a_tag  (bus.i_a_tag),
    .b_ena  (bus.i_b_ena),
    .b_mode (bus.i_b_mode),
    .b_data (bus.i_b_data),
    .b_tag  (bus.i_b_tag),
    .w0     (w0),
    .w1     (w1)
  );

  assign active = ~x_stall & bus.i_stb;
  assign pair   = (w0.ena != '0) && (w1.ena != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_A;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_A: if (active && pair) state_nxt = ST_B;
      ST_B: if (active)         state_nxt = ST_A;
      default:                  state_nxt = ST_A;
    endcase
  end

  always_comb begin
    ack          = 1'b0;
    go_b         = 1'b0;
    issue        = 1'b0;
    iss_addr     = '0;
    iss_w        = '0;
    iss_clr      = 1'b0;
    iss_clr_addr = '0;
    case (state)
      ST_A: begin
        if (active) begin
          if (pair) begin
            // First half of a pair: entry stays in the FIFO until W1 issues.
            go_b     = 1'b1;
            issue    = 1'b1;
            iss_addr = bus.i_addr;
            iss_w    = w0;
          end else begin
            ack          = 1'b1;
            iss_clr      = bus.i_clr;
            iss_clr_addr = bus.i_addr;
            if (w0.ena != '0) begin
              issue    = 1'b1;
              iss_addr = bus.i_addr;
              iss_w    = w0;
            end else if (w1.ena != '0) begin
              issue    = 1'b1;
              iss_addr = bus.i_addr ^ ADDR_W'(1);
              iss_w    = w1;
            end
          end
        end
      end
      ST_B: begin
        if (active) begin
          ack          = 1'b1;
          issue        = 1'b1;
          iss_addr     = cap_addr ^ ADDR_W'(1);
          iss_w        = cap_w1;
          iss_clr      = cap_clr;
          iss_clr_addr = cap_addr;
        end
      end
      default: ;
    endcase
  end

  assign rf_wr     = issue && (iss_w.ena != '0) && !(R0_PROTECT && (iss_addr == '0));
  // The FSM may sit in ST_A with a valid entry during reset; never pop then.
  assign bus.i_ack = ack & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_w1   <= '0;
      cap_addr <= '0;
      cap_clr  <= 1'b0;
    end else if (go_b) begin
      cap_w1   <= w1;
      cap_addr <= bus.i_addr;
      cap_clr  <= bus.i_clr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rf_stb  <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_ena  <= '0;
      bus.rf_data <= '0;
      bus.rf_tag  <= '0;
      bus.sb_clr  <= 1'b0;
      bus.sb_addr <= '0;
    end else begin
      bus.rf_stb  <= rf_wr;
      bus.rf_addr <= rf_wr ? iss_addr   : '0;
      bus.rf_ena  <= rf_wr ? iss_w.ena  : '0;
      bus.rf_data <= rf_wr ? iss_w.data : '0;
      bus.rf_tag  <= rf_wr ? iss_w.tag  : '0;
      bus.sb_clr  <= iss_clr;
      bus.sb_addr <= iss_clr ? iss_clr_addr : '0;
    end
  end

endmodule
